key_expander: RTL and testbench
===============================

# key_expander

Upstream key-schedule stage for `decryption_block`. It takes a 128-bit AES cipher key and expands it iteratively, producing one round per clock. It stores all 11 round keys (rounds 0..10) in an internal register file. The decryption datapath then reads any round key by index, typically in reverse order (10 down to 0), with a registered one-cycle read.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: number of AES-128 rounds; storage depth is `NUM_ROUNDS+1`.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `keyLoad`  in  1: start expansion of `key`; sampled on a rising edge.
- `key`  in  128: cipher key; `key[127:96]` is word w0. Sampled only on the accepted `keyLoad` edge.
- `roundSel`  in  4: round-key index to read, 0..10.
- `busy`  out  1: high while expansion is in progress.
- `keyReady`  out  1: high when all 11 round keys are valid.
- `roundKey`  out  128: registered read of round key `roundSel`.

## Operation
- FSM states: IDLE, EXPAND, READY.
  - IDLE, or READY, with `keyLoad`=1:
    - write `rk[0]` = `key`; round counter `rc` = 1.
    - `busy` = 1, `keyReady` = 0, next state EXPAND.
  - EXPAND, each cycle:
    - compute `rk[rc]` from `rk[rc-1]`; `rc`++.
    - when `rc`==10 is written, next state READY, `busy` = 0, `keyReady` = 1.
  - READY: hold. Another `keyLoad` restarts expansion from the new key.
- Expansion of one round, with `prev` = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {Rcon[rc],24'h0}
  - n0 = w0^t, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3.
  - RotWord is a left byte rotate. Rcon = 01,02,04,08,10,20,40,80,1b,36 for rc = 1..10.
- `keyLoad` during EXPAND is ignored. The current expansion completes using the original key.
- `key` changes after the load edge have no effect.
- Read path: `roundKey` ← `rk[roundSel]` every clock, regardless of state.
  - `roundSel` > 10 gives `roundKey` = 0.
  - Reading an entry not yet written in the current expansion returns its previous content (0 after reset).
- Reset, or `rst` mid-expansion:
  - state IDLE; `rc` = 0; all `rk` entries = 0.
  - `busy` = 0, `keyReady` = 0, `roundKey` = 0.
  - `rst` dominates `keyLoad` in the same cycle.

## Timing
- Load edge E0 (`keyLoad` high): `rk[0]` valid after E0, `busy` = 1 after E0.
- Edges E1..E10 write `rk[1]`..`rk[10]`, one per edge.
- After E10: `keyReady` = 1 and `busy` = 0, so `keyReady` rises 10 cycles after the load edge.
- Read latency is 1 cycle: `roundSel` sampled at edge N gives `roundKey` valid after edge N.
- Simultaneous case: `roundSel`==k sampled on the edge that writes `rk[k]` returns the old value. The new value appears one cycle later; there is no write-through.
- `keyLoad` in READY:
  - `keyReady` falls after the same edge.
  - `rk[1..10]` keep their stale values until overwritten.

## Structure
- Package `aes_pkg`:
  - `typedef logic [127:0] block_t`; `typedef logic [31:0] word_t`.
  - `localparam` Rcon array[1:10].
  - FSM state enum `keyexp_state_t`.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box, shared with the encryption path. Four instances here for SubWord.
- One round of expansion logic is combinational between `rk[rc-1]` and the write port. The register file is a flat 11×128 array.

## Test plan
- Reset then idle:
  - `rst`=1 for 2 cycles → `busy`=0, `keyReady`=0, `roundKey`=0.
  - `roundSel`=0..10 all read 0.
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, pulse `keyLoad`:
  - `keyReady` rises exactly 10 cycles after the load edge.
  - `roundSel`=1 → `a0fafe1788542cb123a339392a6c7605`.
  - `roundSel`=10 → `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `roundSel`=0 → the key itself.
- Key `000102030405060708090a0b0c0d0e0f`:
  - `roundSel`=10 → `13111d7fe3944a17f307a78b4d2b30c5`.
  - Reverse sweep 10..0 gives correct keys, 1-cycle latency each.
- `keyLoad` with key A, then `keyLoad` with key B at cycle 5 of EXPAND → ignored; final round 10 equals key A's.
- `rst` asserted at cycle 4 of EXPAND → next cycle IDLE, all outputs 0, all `rk` entries 0.
  - A following load expands normally.
- Reload in READY with a second key → `keyReady` drops next cycle, returns after 10 cycles, and all round keys match the new key.
- Also `roundSel`=15 → 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key-schedule and cipher datapaths.
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } keyexp_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for round rc; zero outside 1..10 so an idle counter is harmless.
  function automatic logic [7:0] rcon_of(input logic [3:0] rc);
    logic [7:0] val;
    val = 8'h00;
    if (rc >= 4'd1 && rc <= 4'd10) val = RCON[rc];
    return val;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_out = SBOX[i_in];

endmodule

// File: rtl/key_expander.sv
// AES-128 key schedule: expands one round key per clock into an 11-entry register
// file that the decryption datapath reads by index with one cycle of latency.
module key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          keyLoad,
  input  block_t        key,
  input  logic [3:0]    roundSel,
  output logic          busy,
  output logic          keyReady,
  output block_t        roundKey,
  output keyexp_state_t o_dbg_state
);

  localparam int         DEPTH   = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST_RC = 4'(NUM_ROUNDS);

  // Handshake: keyLoad is a single-cycle request accepted on any edge where the
  // block is not expanding; busy high means requests are dropped, not queued.

  keyexp_state_t r_state;
  keyexp_state_t w_state_next;
  logic [3:0]    r_rc;
  block_t        r_rk [DEPTH];
  block_t        r_round_key;

  logic          w_load_accept;
  logic [3:0]    w_prev_idx;
  block_t        w_prev;
  word_t         w_rot;
  word_t         w_sub;
  word_t         w_t;
  word_t         w_n0;
  word_t         w_n1;
  word_t         w_n2;
  word_t         w_n3;
  block_t        w_next_rk;

  // One expansion round, combinational from rk[rc-1] to the write port.
  assign w_prev_idx = (r_rc == 4'd0) ? 4'd0 : r_rc - 4'd1;
  assign w_prev     = r_rk[w_prev_idx];
  assign w_rot      = rot_word(w_prev[31:0]);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_in  (w_rot[8*g +: 8]),
      .o_out (w_sub[8*g +: 8])
    );
  end

  assign w_t       = w_sub ^ {rcon_of(r_rc), 24'h000000};
  assign w_n0      = w_prev[127:96] ^ w_t;
  assign w_n1      = w_n0 ^ w_prev[95:64];
  assign w_n2      = w_n1 ^ w_prev[63:32];
  assign w_n3      = w_n2 ^ w_prev[31:0];
  assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};

  assign w_load_accept = keyLoad && (r_state != EXPAND);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_load_accept) w_state_next = EXPAND;
      EXPAND:  if (r_rc == LAST_RC) w_state_next = READY;
      READY:   if (w_load_accept) w_state_next = EXPAND;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rc        <= 4'd0;
      r_round_key <= '0;
      for (int i = 0; i < DEPTH; i++) r_rk[i] <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_accept) begin
        r_rk[0] <= key;
        r_rc    <= 4'd1;
      end else if (r_state == EXPAND) begin
        r_rk[r_rc] <= w_next_rk;
        r_rc       <= r_rc + 4'd1;
      end
      // Reads see the file before this edge's write: no write-through.
      r_round_key <= (roundSel > LAST_RC) ? '0 : r_rk[roundSel];
    end
  end

  assign busy        = (r_state == EXPAND);
  assign keyReady    = (r_state == READY);
  assign roundKey    = r_round_key;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_expander.sv
// Self-checking bench for key_expander against an arithmetic AES key-schedule model.
module tb_key_expander;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         keyLoad;
  logic [127:0] key;
  logic [3:0]   roundSel;
  logic         busy;
  logic         keyReady;
  logic [127:0] roundKey;
  aes_pkg::keyexp_state_t dbg_state;

  always #5 clk = ~clk;

  key_expander #(.NUM_ROUNDS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .keyLoad     (keyLoad),
    .key         (key),
    .roundSel    (roundSel),
    .busy        (busy),
    .keyReady    (keyReady),
    .roundKey    (roundKey),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_tab [256];
  logic [7:0]   rcon_tab [11];
  logic [127:0] ref_rk   [11];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_tables();
    logic [7:0] inv, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    rcon_tab[0] = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      rcon_tab[i] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  // Textbook word-oriented schedule: w[i] = w[i-4] ^ f(w[i-1]).
  task automatic compute_ref(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rcon_tab[i/4], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Model state: visible register file, the schedule being written, and the
  // queue of round indices still to be written by upcoming edges.
  logic [127:0] mdl_rk  [11];
  logic [127:0] mdl_new [11];
  int           pend_q[$];
  logic         mdl_ready;
  logic [127:0] exp_q[$];

  task automatic model_edge(input logic r, input logic ld, input logic [127:0] k, input logic [3:0] sel);
    int idx;
    if (r) begin
      exp_q.push_back(128'h0);
      for (int i = 0; i < 11; i++) mdl_rk[i] = 128'h0;
      pend_q.delete();
      mdl_ready = 1'b0;
    end else begin
      exp_q.push_back((sel <= 4'd10) ? mdl_rk[sel] : 128'h0);
      if (pend_q.size() != 0) begin
        idx = pend_q.pop_front();
        mdl_rk[idx] = mdl_new[idx];
        if (pend_q.size() == 0) mdl_ready = 1'b1;
      end else if (ld) begin
        compute_ref(k);
        for (int i = 0; i < 11; i++) mdl_new[i] = ref_rk[i];
        mdl_rk[0] = k;
        for (int i = 1; i <= 10; i++) pend_q.push_back(i);
        mdl_ready = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic ld, input logic [127:0] k, input logic [3:0] sel);
    logic [127:0] exp_rk;
    rst = r; keyLoad = ld; key = k; roundSel = sel;
    model_edge(r, ld, k, sel);
    @(posedge clk);
    @(negedge clk);
    check("busy", {127'h0, busy}, {127'h0, pend_q.size() != 0});
    check("keyReady", {127'h0, keyReady}, {127'h0, mdl_ready});
    exp_rk = exp_q.pop_front();
    check("roundKey", roundKey, exp_rk);
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_step();
    step(1'b0, 1'b0, rand_key(), 4'($urandom_range(0, 15)));
  endtask

  task automatic load(input logic [127:0] k);
    step(1'b0, 1'b1, k, 4'($urandom_range(0, 15)));
  endtask

  task automatic wait_ready(input int exp_cycles);
    int cnt;
    cnt = 0;
    while (!keyReady && cnt < 40) begin
      idle_step();
      cnt++;
    end
    check("ready_latency", 128'(cnt), 128'(exp_cycles));
  endtask

  task automatic sweep_down();
    for (int s = 10; s >= 0; s--) step(1'b0, 1'b0, rand_key(), 4'(s));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] key;
    logic [3:0]   sel;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] key_a, key_b;
    rst = 1'b1; keyLoad = 1'b0; key = '0; roundSel = '0;
    mdl_ready = 1'b0;
    for (int i = 0; i < 11; i++) mdl_rk[i] = 128'h0;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd15, 128'h0};
    vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd11, 128'h0};

    build_tables();

    // Reset for two cycles, then every index reads zero.
    step(1'b1, 1'b0, '0, 4'd0);
    step(1'b1, 1'b1, rand_key(), 4'd0);
    for (int s = 0; s <= 10; s++) step(1'b0, 1'b0, rand_key(), 4'(s));
    step(1'b0, 1'b0, '0, 4'd15);

    // Known-answer vectors, each from a fresh load.
    for (int v = 0; v < 6; v++) begin
      load(vecs[v].key);
      wait_ready(10);
      step(1'b0, 1'b0, rand_key(), vecs[v].sel);
      check($sformatf("vec%0d", v), roundKey, vecs[v].exp);
    end

    // Reverse sweep of the second FIPS key.
    sweep_down();

    // Load during expansion is dropped; round 10 belongs to the first key.
    key_a = rand_key();
    key_b = rand_key();
    load(key_a);
    for (int i = 0; i < 4; i++) idle_step();
    step(1'b0, 1'b1, key_b, 4'd0);
    wait_ready(5);
    compute_ref(key_a);
    step(1'b0, 1'b0, rand_key(), 4'd10);
    check("ignored_load_rk10", roundKey, ref_rk[10]);

    // Reset mid-expansion clears everything; a following load still works.
    load(rand_key());
    for (int i = 0; i < 3; i++) idle_step();
    step(1'b1, 1'b1, rand_key(), 4'd3);
    sweep_down();
    load(rand_key());
    wait_ready(10);
    sweep_down();

    // Reload from READY: keyReady drops at once and stale rounds are readable meanwhile.
    load(rand_key());
    wait_ready(10);
    load(rand_key());
    wait_ready(10);
    sweep_down();

    // Random traffic, including loads while busy and occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           rand_key(), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
